addsub_resp_checker: RTL and testbench
======================================

// Module: addsub_resp_checker
// PURPOSE
//  Synthesizable response checker at the output end of the 4-bit adder/subtractor:
//  - consumes one stimulus/response vector per handshake: operands, mode, DUT result, DUT carry.
//  - recomputes the expected result and compares it with the DUT result.
//  - counts passes and fails over a run of N vectors and captures the first mismatch.
//  - signals completion so the board or bench reads pass/fail without waveforms.
// PARAMETERS
//  WIDTH  4   operand/result width
//  CNT_W  16  width of vector-count, pass and fail counters
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      1-cycle pulse; accepted only in IDLE or DONE
//  num_vec     in   CNT_W  vectors in the run; sampled on accepted start
//  in_valid    in   1      vector present on in_* this cycle
//  in_ready    out  1      checker accepts a vector this cycle
//  in_a        in   WIDTH  operand a
//  in_b        in   WIDTH  operand b
//  in_m        in   1      mode: 0 = add (a+b), 1 = subtract (a-b = a+~b+1)
//  in_r        in   WIDTH  DUT result
//  in_cout     in   1      DUT carry out; in subtract mode 1 = no borrow
//  busy        out  1      FSM in RUN
//  done        out  1      FSM in DONE; held until the next start
//  pass_cnt    out  CNT_W  vectors matched
//  fail_cnt    out  CNT_W  vectors mismatched
//  err         out  1      sticky; set on first mismatch
//  ff_vec      out  3*WIDTH+2  first failing {a,b,m,r,cout} as received
//  ff_exp      out  WIDTH+1    expected {cout,r} for the first failure
// BEHAVIOUR
//  - Reset: FSM=IDLE, in_ready=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, err=0, ff_vec=0, ff_exp=0.
//  - Reset asserted mid-run aborts the run immediately; no partial result survives.
//  - FSM IDLE -> RUN on start:
//    - clear counters, err, ff_*; load remaining count = num_vec.
//    - start with num_vec=0 goes IDLE -> DONE directly; counters stay 0.
//  - FSM RUN -> DONE when the last vector's compare has committed.
//  - FSM DONE -> RUN on start, with the same clear rules as IDLE.
//  - start is ignored while in RUN.
//  - Handshake:
//    - in_ready=1 in RUN while remaining count > 0.
//    - a transfer occurs when in_valid && in_ready.
//    - in_valid outside RUN is ignored and is not an error.
//  - Expected value: {exp_cout, exp_r} = in_a + (in_b ^ {WIDTH{in_m}}) + in_m, computed WIDTH+1 bits wide.
//  - Pipeline:
//    - cycle T, transfer: register the vector and the expected value; decrement the remaining count.
//    - cycle T+1: compare {in_cout, in_r} with {exp_cout, exp_r}; increment pass_cnt or fail_cnt.
//    - the counter update is visible after the T+1 edge; latency is 2 edges.
//    - back-to-back transfers every cycle, one vector per clock.
//  - The last transfer drops in_ready the following cycle. done asserts on the edge after the last compare; busy deasserts on that same edge.
//  - Mismatch covers r or cout:
//    - on the first mismatch of a run, set err and capture ff_vec and ff_exp.
//    - later mismatches only increment fail_cnt.
//  - Counters saturate at all-ones and never wrap. num_vec larger than the counter range is legal.
// STRUCTURE
//  - Shared include addsub_defs.vh:
//    - FSM state localparams: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
//    - mode constants: MODE_ADD=1'b0, MODE_SUB=1'b1.
//    - default WIDTH.
//  - Sub-module addsub_ref_model: combinational golden adder/subtractor, parameterized by WIDTH, inputs a, b, m, outputs {cout, r}.
//  - Top level: FSM, remaining counter, 1-stage compare pipeline, counters, first-fail capture.
// TESTING
//  1. Reset, then start with num_vec=3. Drive one vector per cycle, each pairing DUT outputs with the same inputs:
//     - a=9, b=8, m=0; DUT r=1, cout=1. Here 9+8=17, so the 4-bit result is 1 with carry 1.
//     - a=4'b1010, b=4'b1000, m=1; DUT r=2, cout=1.
//     - a=15, b=14, m=1; DUT r=1, cout=1.
//     Required: pass_cnt=3, fail_cnt=0, err=0; done 2 edges after the last transfer.
//  2. Start with num_vec=2:
//     - a=9, b=10, m=1 with DUT r=4'hF, cout=0: must pass.
//     - a=15, b=14, m=0 with DUT r=4'hD, cout=0: must fail, since the correct response is r=4'hD, cout=1.
//     Required: fail_cnt=1, err=1, ff_vec={F,E,0,D,0}, ff_exp={1,D}.
//  3. Stall: in_valid toggles 1,0,0,1 with num_vec=2. Only 2 transfers are counted; in_ready drops after the second.
//  4. start with num_vec=0 -> done the next cycle, in_ready never asserts, all counters 0.
//  5. Assert rst for 1 cycle mid-run, after 1 of 4 vectors: all outputs return to reset values asynchronously, before the next clk edge; FSM=IDLE.
//  6. Second start from DONE after a failing run: err, fail_cnt and ff_* clear; a start pulse during RUN is ignored and num_vec is not reloaded.

Source files
------------

// File: rtl/addsub_resp_checker_pkg.sv
// Shared constants for the adder/subtractor response checker: FSM states, mode encodings, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package addsub_resp_checker_pkg;

    // Default operand/result width and counter width
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 16;

    // Mode encodings on the m input
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Checker run states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_resp_checker_ref_model.sv
// Golden adder/subtractor: {cout, r} = a + (b ^ {WIDTH{m}}) + m, computed WIDTH+1 bits wide.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module addsub_ref_model
    import addsub_resp_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             cout,
    output logic [WIDTH-1:0] r
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Subtract is a + ~b + 1, so the mode bit both inverts b and injects the carry-in
    always_comb begin
        sub   = (m == MODE_SUB);
        b_eff = b ^ {WIDTH{sub}};
        sum   = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);
        cout  = sum[WIDTH];
        r     = sum[WIDTH-1:0];
    end

endmodule

// File: rtl/addsub_resp_checker.sv
// Response checker: recomputes each {cout,r}, counts pass/fail over a run, captures the first mismatch.
// Latency: transfer registers at edge T, counters update at edge T+1, done asserts at edge T+2 after the last transfer.
// Backpressure: in_ready high in RUN while vectors remain; one vector per clock, no stalls of its own.
module addsub_resp_checker
    import addsub_resp_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_vec,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_m,
    input  logic [WIDTH-1:0]   in_r,
    input  logic               in_cout,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               err,
    output logic [3*WIDTH+1:0] ff_vec,
    output logic [WIDTH:0]     ff_exp
);

    localparam int               VEC_W   = 3*WIDTH + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   rem_q;
    logic               start_ok;
    logic               xfer;
    logic               run_over;

    logic               exp_cout;
    logic [WIDTH-1:0]   exp_r;

    logic               cmp_vld;
    logic [VEC_W-1:0]   cmp_vec;
    logic [WIDTH:0]     cmp_exp;
    logic [WIDTH:0]     cmp_act;
    logic               cmp_bad;

    addsub_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .a    (in_a),
        .b    (in_b),
        .m    (in_m),
        .cout (exp_cout),
        .r    (exp_r)
    );

    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign xfer     = in_valid && in_ready;
    // Run ends once every vector has been taken and the compare stage has drained
    assign run_over = (rem_q == '0) && !cmp_vld;
    // Captured vector is {a,b,m,r,cout}; rebuild {cout,r} to line up with the expected value
    assign cmp_act  = {cmp_vec[0], cmp_vec[WIDTH:1]};
    assign cmp_bad  = (cmp_act != cmp_exp);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a zero-length run skips RUN; start inside RUN is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = (num_vec == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (run_over) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state and remaining count
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_RUN: begin
                busy     = 1'b1;
                in_ready = (rem_q != '0);
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Remaining-vector counter: loaded on an accepted start, one down per transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
        end else if (start_ok) begin
            rem_q <= num_vec;
        end else if (xfer) begin
            rem_q <= rem_q - CNT_W'(1);
        end
    end

    // Compare stage: hold the received vector and its expected response for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_vld <= 1'b0;
            cmp_vec <= '0;
            cmp_exp <= '0;
        end else begin
            cmp_vld <= xfer;
            if (xfer) begin
                cmp_vec <= {in_a, in_b, in_m, in_r, in_cout};
                cmp_exp <= {exp_cout, exp_r};
            end
        end
    end

    // Result counters and first-failure capture; counters saturate rather than wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
            ff_vec   <= '0;
            ff_exp   <= '0;
        end else if (start_ok) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
            ff_vec   <= '0;
            ff_exp   <= '0;
        end else if (cmp_vld) begin
            if (!cmp_bad) begin
                if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + CNT_W'(1);
                end
            end else begin
                if (fail_cnt != CNT_MAX) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
                if (!err) begin
                    err    <= 1'b1;
                    ff_vec <= cmp_vec;
                    ff_exp <= cmp_exp;
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_resp_checker.sv
// Self-checking bench for addsub_resp_checker: directed scenarios plus randomized runs against a behavioural model.
// Latency: model tracks transfer, compare commit and run completion at the edge level.
// Backpressure: stimulus drives in_valid freely; the model decides acceptance from its own remaining count.
module tb_addsub_resp_checker;

    localparam int WIDTH = 4;
    localparam int CNT_W = 16;
    localparam int VEC_W = 3*WIDTH + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   num_vec = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a = '0;
    logic [WIDTH-1:0]   in_b = '0;
    logic               in_m = 1'b0;
    logic [WIDTH-1:0]   in_r = '0;
    logic               in_cout = 1'b0;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   pass_cnt;
    logic [CNT_W-1:0]   fail_cnt;
    logic               err;
    logic [VEC_W-1:0]   ff_vec;
    logic [WIDTH:0]     ff_exp;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    addsub_resp_checker #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_vec  (num_vec),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_m     (in_m),
        .in_r     (in_r),
        .in_cout  (in_cout),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .err      (err),
        .ff_vec   (ff_vec),
        .ff_exp   (ff_exp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic: subtract as a - b offset by 16 so the carry bit means "no borrow"
    function automatic logic [4:0] gold(input logic [3:0] a, input logic [3:0] b, input logic m);
        int s;
        s = m ? (int'(a) + 16 - int'(b)) : (int'(a) + int'(b));
        return s[4:0];
    endfunction

    // ---------------- behavioural model ----------------
    int          phase;          // 0 idle, 1 running, 2 finished
    int unsigned m_num, m_acc, m_pass, m_fail;
    bit          m_err;
    logic [13:0] m_ffvec;
    logic [4:0]  m_ffexp;
    bit          pend;
    logic [13:0] pend_vec;
    logic [4:0]  pend_exp;
    logic [4:0]  pend_act;

    initial begin
        bit finished;
        bit take;
        phase = 0; m_num = 0; m_acc = 0; m_pass = 0; m_fail = 0; m_err = 0;
        m_ffvec = '0; m_ffexp = '0; pend = 0; pend_vec = '0; pend_exp = '0; pend_act = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                phase = 0; m_num = 0; m_acc = 0; m_pass = 0; m_fail = 0; m_err = 0;
                m_ffvec = '0; m_ffexp = '0; pend = 0;
            end else if (phase != 1) begin
                if (start) begin
                    m_pass = 0; m_fail = 0; m_err = 0; m_ffvec = '0; m_ffexp = '0;
                    m_num = num_vec; m_acc = 0; pend = 0;
                    phase = (num_vec == 0) ? 2 : 1;
                end
            end else begin
                finished = (m_acc == m_num) && !pend;
                take     = in_valid && (m_acc < m_num);
                if (pend) begin
                    if (pend_act == pend_exp) begin
                        if (m_pass < 65535) m_pass++;
                    end else begin
                        if (m_fail < 65535) m_fail++;
                        if (!m_err) begin
                            m_err   = 1;
                            m_ffvec = pend_vec;
                            m_ffexp = pend_exp;
                        end
                    end
                    pend = 0;
                end
                if (take) begin
                    pend     = 1;
                    pend_vec = {in_a, in_b, in_m, in_r, in_cout};
                    pend_act = {in_cout, in_r};
                    pend_exp = gold(in_a, in_b, in_m);
                    m_acc++;
                end
                if (finished) phase = 2;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("in_ready", in_ready, (phase == 1) && (m_acc < m_num));
                chk("busy",     busy,     phase == 1);
                chk("done",     done,     phase == 2);
                chk("pass_cnt", pass_cnt, m_pass);
                chk("fail_cnt", fail_cnt, m_fail);
                chk("err",      err,      m_err);
                chk("ff_vec",   ff_vec,   m_ffvec);
                chk("ff_exp",   ff_exp,   m_ffexp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input logic [CNT_W-1:0] n);
        in_valid = 1'b0;
        start    = 1'b1;
        num_vec  = n;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic drive_vec(input logic [3:0] a, input logic [3:0] b, input logic m,
                             input logic [3:0] r, input logic c);
        in_valid = 1'b1;
        in_a = a; in_b = b; in_m = m; in_r = r; in_cout = c;
        @(negedge clk);
    endtask

    task automatic drive_good(input logic [3:0] a, input logic [3:0] b, input logic m);
        logic [4:0] g;
        g = gold(a, b, m);
        drive_vec(a, b, m, g[3:0], g[4]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [VEC_W-1:0] ffv_lit;

        // pin the model's arithmetic with hand-computed responses
        chk("gold_9p8",   gold(4'd9, 4'd8, 1'b0),   5'h11);
        chk("gold_15p14", gold(4'd15, 4'd14, 1'b0), 5'h1D);
        chk("gold_9m10",  gold(4'd9, 4'd10, 1'b1),  5'h0F);
        chk("gold_10m8",  gold(4'd10, 4'd8, 1'b1),  5'h12);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy",     busy,     0);
        chk("rst_done",     done,     0);
        chk("rst_pass",     pass_cnt, 0);
        chk("rst_fail",     fail_cnt, 0);
        chk("rst_err",      err,      0);
        chk("rst_ff_vec",   ff_vec,   0);
        chk("rst_ff_exp",   ff_exp,   0);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // test 1: three matching vectors back to back
        pulse_start(16'd3);
        drive_vec(4'd9, 4'd8, 1'b0, 4'd1, 1'b1);
        drive_vec(4'b1010, 4'b1000, 1'b1, 4'd2, 1'b1);
        drive_vec(4'd15, 4'd14, 1'b1, 4'd1, 1'b1);
        in_valid = 1'b0;
        chk("t1_ready_after_last", in_ready, 0);
        chk("t1_done_early", done, 0);
        @(negedge clk);
        chk("t1_pass", pass_cnt, 3);
        chk("t1_done_one_edge", done, 0);
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_fail", fail_cnt, 0);
        chk("t1_err",  err, 0);

        // test 2: one pass, one carry mismatch
        pulse_start(16'd2);
        drive_vec(4'd9, 4'd10, 1'b1, 4'hF, 1'b0);
        drive_vec(4'd15, 4'd14, 1'b0, 4'hD, 1'b0);
        idle(2);
        ffv_lit = {4'hF, 4'hE, 1'b0, 4'hD, 1'b0};
        chk("t2_pass",   pass_cnt, 1);
        chk("t2_fail",   fail_cnt, 1);
        chk("t2_err",    err, 1);
        chk("t2_ff_vec", ff_vec, ffv_lit);
        chk("t2_ff_exp", ff_exp, 5'h1D);
        chk("t2_done",   done, 1);

        // test 3: stalls between transfers
        pulse_start(16'd2);
        drive_good(4'd3, 4'd5, 1'b0);
        idle(2);
        drive_good(4'd7, 4'd2, 1'b1);
        in_valid = 1'b0;
        chk("t3_ready_drop", in_ready, 0);
        idle(2);
        chk("t3_pass", pass_cnt, 2);
        chk("t3_err",  err, 0);
        chk("t3_done", done, 1);

        // test 4: zero-length run
        pulse_start(16'd0);
        chk("t4_done",  done, 1);
        chk("t4_ready", in_ready, 0);
        chk("t4_pass",  pass_cnt, 0);
        chk("t4_fail",  fail_cnt, 0);
        idle(1);
        chk("t4_ready2", in_ready, 0);

        // test 6: restart from DONE after a failing run, start during RUN ignored
        pulse_start(16'd1);
        drive_vec(4'd1, 4'd1, 1'b0, 4'd0, 1'b0);
        idle(2);
        chk("t6_err_before", err, 1);
        pulse_start(16'd4);
        chk("t6_err_clr",  err, 0);
        chk("t6_fail_clr", fail_cnt, 0);
        chk("t6_ffv_clr",  ff_vec, 0);
        chk("t6_ffe_clr",  ff_exp, 0);
        drive_good(4'd4, 4'd9, 1'b1);
        start = 1'b1;
        num_vec = 16'd1;
        drive_good(4'd12, 4'd6, 1'b0);
        start = 1'b0;
        drive_good(4'd0, 4'd15, 1'b1);
        drive_good(4'd8, 4'd8, 1'b0);
        idle(2);
        chk("t6_pass", pass_cnt, 4);
        chk("t6_done", done, 1);

        // test 5: asynchronous reset mid-run
        pulse_start(16'd4);
        drive_good(4'd2, 4'd3, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_pass_pre", pass_cnt, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy",  busy, 0);
        chk("t5_ready", in_ready, 0);
        chk("t5_done",  done, 0);
        chk("t5_pass",  pass_cnt, 0);
        chk("t5_err",   err, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_done", done, 0);

        // randomized runs with stalls, errors and stray start pulses
        for (int run = 0; run < 30; run++) begin
            int         guard;
            logic [3:0] a;
            logic [3:0] b;
            logic       m;
            logic [4:0] g;
            pulse_start(CNT_W'($urandom_range(1, 20)));
            guard = 0;
            while (done !== 1'b1 && guard < 400) begin
                a = 4'($urandom);
                b = 4'($urandom);
                m = 1'($urandom);
                g = gold(a, b, m);
                in_valid = ($urandom_range(0, 9) < 7);
                in_a = a; in_b = b; in_m = m;
                if ($urandom_range(0, 3) == 0) begin
                    in_r    = 4'($urandom);
                    in_cout = 1'($urandom);
                end else begin
                    in_r    = g[3:0];
                    in_cout = g[4];
                end
                start   = ($urandom_range(0, 15) == 0);
                num_vec = CNT_W'($urandom_range(0, 30));
                @(negedge clk);
                guard++;
            end
            start = 1'b0;
            in_valid = 1'b0;
            chk("rnd_run_completes", guard < 400, 1);
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
